log2_pipe: RTL and testbench
============================

Name: log2_pipe

Overview:
- Parametrised, fully pipelined fixed-point logarithm unit for the MFCC chain, between the mel filterbank and the DCT.
- Takes unsigned mel energies and computes true log2 using leading-one detection, normalisation and an interpolated correction LUT.
- Optionally scales the result to natural log, per sample.
- Streams at one sample per cycle with valid/ready backpressure.

Parameters:
IN_W, 32, input word width (unsigned)
IN_FRAC, 16, fractional bits of input
OUT_W, 16, output width (signed two's complement)
OUT_FRAC, 10, fractional bits of output
LUT_BITS, 6, mantissa bits indexing correction LUT (2^LUT_BITS+1 entries)
LN2_Q16, 45426, ln(2) in Q0.16 for natural-log mode

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_data  in  IN_W  unsigned energy, Q(IN_W-IN_FRAC).IN_FRAC
in_ln_mode  in  1  1 = natural log, 0 = log2; sampled with in_data
in_valid  in  1  input sample valid
in_ready  out  1  unit can accept a sample this cycle
out_data  out  OUT_W  signed log result, OUT_FRAC fractional bits
out_zero  out  1  input was zero; out_data forced to floor
out_valid  out  1  output valid
out_ready  in  1  downstream accepts output

Behaviour:
- Interface decision: one clock clk; reset rst is synchronous and active-high.
- Reset: all stage valids 0, out_valid=0, out_data=0, out_zero=0. in_ready=1 in the cycle after reset. Reset mid-stream discards every in-flight sample without emitting it.
- Pipeline enable:
  - en = !out_valid | out_ready; in_ready = en.
  - A transfer occurs when in_valid & in_ready.
  - When en=0, every stage holds its data and valid bit. No bubbles are inserted and no data is dropped.
- Latency: 5 enabled cycles from input transfer to out_valid. Throughput is 1 per cycle when out_ready=1. Valid bits are shifted even for bubbles.
- S1, leading-one detect:
  - p = index of the MSB set in in_data.
  - zero = (in_data==0).
  - k = p - IN_FRAC, signed, width clog2(IN_W)+1 (range -16..15 at defaults).
- S2, normalise:
  - Shift left by (IN_W-1-p). Drop the leading 1.
  - f = the next OUT_FRAC+LUT_BITS bits as the mantissa fraction in [0,1). Zero-fill when the input has fewer bits.
- S3, correction:
  - i = f[top LUT_BITS]; r = the remaining bits.
  - c = C[i] + (((C[i+1]-C[i])*r) >> width(r)), rounded to nearest.
  - C[j] = round((log2(1+j/2^L) - j/2^L) * 2^OUT_FRAC), for j=0..2^L. C[0]=C[2^L]=0.
- S4, combine:
  - y = (k << OUT_FRAC) + f_top(OUT_FRAC bits) + c.
  - The sum is carried in OUT_W+2 bits.
  - Accuracy: |y - ideal| ≤ 1 LSB for all nonzero inputs.
- S5, output:
  - If ln_mode: y = round_half_up(y * LN2_Q16 / 2^16); the product is signed.
  - If zero: out_data = most negative OUT_W value (0x8000 at defaults), out_zero=1. Zero takes priority over ln_mode.
  - Otherwise, saturate y to the OUT_W signed range; out_zero=0.
- in_ln_mode and zero flags travel with their sample through every stage.
- Simultaneous in transfer and out transfer in the same cycle is legal and required for full throughput.

Decomposition:
- Package mfcc_log_pkg holds:
  - the default parameter constants;
  - the LOG_FLOOR constant;
  - the function computing the characteristic width;
  - a typedef for the per-stage sideband struct {valid, zero, ln_mode, k}.
- Sub-module log2_corr_lut: synchronous-read-free combinational ROM of 2^LUT_BITS+1 signed OUT_FRAC-bit entries. It is generated from the formula above at elaboration and indexed by i and i+1 (dual read).

Test Plan:
- ln_mode=0, out_ready=1; inputs 0x00010000, 0x00020000, 0x00008000 back-to-back -> out_data 0x0000, 0x0400, 0xFC00 on consecutive cycles, first output 5 cycles after the first transfer.
- Input 0x00030000 -> out_data 0x0657 ±1. Input 0xFFFFFFFF -> 0x4000 ±1. Input 0x00000001 -> 0xC000 (-16.0).
- Input 0x00000000, with ln_mode=0 and again with ln_mode=1 -> out_data 0x8000, out_zero=1 both times.
- ln_mode=1 with 0x00020000 -> 0x02C6 ±1; same sample with ln_mode=0 immediately after -> 0x0400, confirming the per-sample mode sideband.
- Backpressure:
  - Stream 20 random values while out_ready toggles pseudo-randomly.
  - Required: out_data sequence matches the reference model in order, with no loss or duplication.
  - Required: out_data/out_valid stable while out_valid & !out_ready.
  - Required: in_ready=0 exactly when out_valid & !out_ready.
- Assert rst for 1 cycle with 3 samples in flight -> no out_valid afterwards until new input. The next sample emerges after exactly 5 cycles with the correct value.

Source files
------------

// File: rtl/mfcc_log_pkg.sv
// Shared constants, sideband type and helpers for the MFCC log2 pipeline.
package mfcc_log_pkg;

   localparam int IN_W_DEF     = 32;
   localparam int IN_FRAC_DEF  = 16;
   localparam int OUT_W_DEF    = 16;
   localparam int OUT_FRAC_DEF = 10;
   localparam int LUT_BITS_DEF = 6;
   localparam int LN2_Q16_DEF  = 45426;

   localparam logic [OUT_W_DEF-1:0] LOG_FLOOR = 16'h8000;

   // Sideband k field is wide enough for input words up to 128 bits.
   localparam int K_SB_W = 8;

   function automatic int char_width(input int in_w);
      return $clog2(in_w) + 32'sd1;
   endfunction

   typedef struct packed {
      logic                     valid;
      logic                     zero;
      logic                     ln_mode;
      logic signed [K_SB_W-1:0] k;
   } stage_sb_t;

   localparam stage_sb_t SB_IDLE = '{valid: 1'b0, zero: 1'b0, ln_mode: 1'b0, k: 8'sd0};

endpackage

// File: rtl/log2_corr_lut.sv
// Dual-read combinational ROM holding the log2(1+x)-x correction curve,
// built from the closed-form expression at elaboration time.
module log2_corr_lut
   import mfcc_log_pkg::*;
#(
   parameter int OUT_FRAC = OUT_FRAC_DEF,
   parameter int LUT_BITS = LUT_BITS_DEF
) (
   input  logic [LUT_BITS-1:0]        idx,
   output logic signed [OUT_FRAC-1:0] c_lo,
   output logic signed [OUT_FRAC-1:0] c_hi
);

   localparam int N  = (32'sd1 <<< LUT_BITS) + 32'sd1;
   localparam int IW = $clog2(N);

   function automatic logic signed [OUT_FRAC-1:0] corr_entry(input int j);
      real x;
      real v;
      x = real'(j) / real'(32'sd1 <<< LUT_BITS);
      v = ($ln(1.0 + x) / $ln(2.0) - x) * real'(32'sd1 <<< OUT_FRAC);
      return OUT_FRAC'($rtoi(v + 0.5));
   endfunction

   logic signed [OUT_FRAC-1:0] rom_s [N];

   for (genvar j = 0; j < N; j++) begin : g_rom
      localparam logic signed [OUT_FRAC-1:0] ENTRY = corr_entry(j);
      assign rom_s[j] = ENTRY;
   end

   // Read the segment end points for linear interpolation.
   always_comb begin
      c_lo = rom_s[{1'b0, idx}];
      c_hi = rom_s[{1'b0, idx} + IW'(1)];
   end

endmodule

// File: rtl/log2_pipe.sv
// Five-stage fixed-point log2 / ln unit with valid/ready backpressure:
// leading-one detect, normalise, LUT correction, combine, scale and saturate.
module log2_pipe
   import mfcc_log_pkg::*;
#(
   parameter int IN_W     = IN_W_DEF,
   parameter int IN_FRAC  = IN_FRAC_DEF,
   parameter int OUT_W    = OUT_W_DEF,
   parameter int OUT_FRAC = OUT_FRAC_DEF,
   parameter int LUT_BITS = LUT_BITS_DEF,
   parameter int LN2_Q16  = LN2_Q16_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_ln_mode,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_zero,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int PW       = $clog2(IN_W);
   localparam int K_W      = char_width(IN_W);
   localparam int F_W      = OUT_FRAC + LUT_BITS;
   localparam int PRW      = 2 * OUT_FRAC + 2;
   localparam int YW       = OUT_W + 2;
   localparam int MW       = YW + 18;
   localparam int LN_SHIFT = 16;

   localparam logic [OUT_W-1:0]      FLOOR_C = {LOG_FLOOR[OUT_W_DEF-1], {(OUT_W-1){1'b0}}};
   localparam logic signed [YW-1:0]  Y_MAX   = YW'((32'sd1 <<< (OUT_W - 1)) - 32'sd1);
   localparam logic signed [YW-1:0]  Y_MIN   = YW'(-(32'sd1 <<< (OUT_W - 1)));
   localparam logic signed [17:0]    LN2_S   = 18'(LN2_Q16);
   localparam logic signed [MW-1:0]  HALF_LN = MW'(32'sd1 <<< (LN_SHIFT - 1));
   localparam logic signed [PRW-1:0] HALF_C  = PRW'(32'sd1 <<< (OUT_FRAC - 1));

   logic                       en_s;
   logic                       out_valid_r;
   logic [OUT_W-1:0]           out_data_r;
   logic                       out_zero_r;

   logic [PW-1:0]              p_s;
   logic [PW-1:0]              sh_s;
   logic signed [K_W-1:0]      k_s;
   stage_sb_t                  sb1_d_s;
   stage_sb_t                  sb1_r;
   logic [IN_W-1:0]            d1_r;
   logic [PW-1:0]              sh1_r;

   logic [F_W-1:0]             f_s;
   stage_sb_t                  sb2_r;
   logic [F_W-1:0]             f2_r;

   logic [LUT_BITS-1:0]        idx_s;
   logic [OUT_FRAC-1:0]        r_s;
   logic signed [OUT_FRAC-1:0] c_lo_s;
   logic signed [OUT_FRAC-1:0] c_hi_s;
   logic signed [OUT_FRAC:0]   diff_s;
   logic signed [PRW-1:0]      prod_s;
   logic signed [OUT_FRAC+1:0] c_s;
   stage_sb_t                  sb3_r;
   logic [OUT_FRAC-1:0]        ftop3_r;
   logic signed [OUT_FRAC+1:0] c3_r;

   logic signed [K_SB_W-1:0]   k3_s;
   logic signed [YW-1:0]       y_s;
   logic                       v4_r;
   logic                       zero4_r;
   logic                       ln4_r;
   logic signed [YW-1:0]       y4_r;

   logic signed [MW-1:0]       prod_ln_s;
   logic signed [YW-1:0]       ysel_s;
   logic [OUT_W-1:0]           odata_s;

   assign en_s      = ~out_valid_r | out_ready;
   assign in_ready  = en_s;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_zero  = out_zero_r;

   // S1: leading-one position, characteristic and sideband for the incoming word.
   always_comb begin
      p_s = {PW{1'b0}};
      for (int i = 0; i < IN_W; i++) begin
         if (in_data[i]) p_s = PW'(i);
         else            p_s = p_s;
      end
      sh_s            = PW'(IN_W - 1) - p_s;
      k_s             = $signed(K_W'(p_s)) - $signed(K_W'(IN_FRAC));
      sb1_d_s.valid   = in_valid;
      sb1_d_s.zero    = (in_data == {IN_W{1'b0}});
      sb1_d_s.ln_mode = in_ln_mode;
      sb1_d_s.k       = K_SB_W'(k_s);
   end

   // S2: normalise so the leading one falls off the top; zero-fill short words.
   always_comb begin
      f_s = F_W'(({d1_r, {F_W{1'b0}}} << sh1_r) >> (IN_W - 1));
   end

   assign idx_s = f2_r[F_W-1 -: LUT_BITS];
   assign r_s   = f2_r[OUT_FRAC-1:0];

   log2_corr_lut #(
      .OUT_FRAC (OUT_FRAC),
      .LUT_BITS (LUT_BITS)
   ) u_corr_lut (
      .idx  (idx_s),
      .c_lo (c_lo_s),
      .c_hi (c_hi_s)
   );

   // S3: interpolate between neighbouring correction entries, rounded to nearest.
   always_comb begin
      diff_s = (OUT_FRAC+1)'(c_hi_s) - (OUT_FRAC+1)'(c_lo_s);
      prod_s = PRW'(diff_s) * PRW'($signed({1'b0, r_s}));
      c_s    = (OUT_FRAC+2)'(c_lo_s) + (OUT_FRAC+2)'((prod_s + HALF_C) >>> OUT_FRAC);
   end

   // S4 combine, then S5 optional ln scaling, zero floor and saturation.
   always_comb begin
      k3_s      = sb3_r.k;
      y_s       = (YW'(k3_s) <<< OUT_FRAC) + $signed(YW'(ftop3_r)) + YW'(c3_r);
      prod_ln_s = MW'(y4_r) * MW'(LN2_S);
      if (ln4_r) ysel_s = YW'((prod_ln_s + HALF_LN) >>> LN_SHIFT);
      else       ysel_s = y4_r;
      if (zero4_r)             odata_s = FLOOR_C;
      else if (ysel_s > Y_MAX) odata_s = Y_MAX[OUT_W-1:0];
      else if (ysel_s < Y_MIN) odata_s = Y_MIN[OUT_W-1:0];
      else                     odata_s = ysel_s[OUT_W-1:0];
   end

   // Pipeline registers: reset flushes every stage; all stages advance together on en.
   always_ff @(posedge clk) begin
      if (rst) begin
         sb1_r       <= SB_IDLE;
         d1_r        <= {IN_W{1'b0}};
         sh1_r       <= {PW{1'b0}};
         sb2_r       <= SB_IDLE;
         f2_r        <= {F_W{1'b0}};
         sb3_r       <= SB_IDLE;
         ftop3_r     <= {OUT_FRAC{1'b0}};
         c3_r        <= {(OUT_FRAC+2){1'b0}};
         v4_r        <= 1'b0;
         zero4_r     <= 1'b0;
         ln4_r       <= 1'b0;
         y4_r        <= {YW{1'b0}};
         out_valid_r <= 1'b0;
         out_zero_r  <= 1'b0;
         out_data_r  <= {OUT_W{1'b0}};
      end else if (en_s) begin
         sb1_r       <= sb1_d_s;
         d1_r        <= in_data;
         sh1_r       <= sh_s;
         sb2_r       <= sb1_r;
         f2_r        <= f_s;
         sb3_r       <= sb2_r;
         ftop3_r     <= f2_r[F_W-1 -: OUT_FRAC];
         c3_r        <= c_s;
         v4_r        <= sb3_r.valid;
         zero4_r     <= sb3_r.zero;
         ln4_r       <= sb3_r.ln_mode;
         y4_r        <= y_s;
         out_valid_r <= v4_r;
         out_zero_r  <= zero4_r;
         out_data_r  <= odata_s;
      end
   end

endmodule

// File: tb/tb_log2_pipe.sv
// Scoreboard bench for log2_pipe: directed values, backpressure stream and mid-stream reset.
module tb_log2_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_ln_mode;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_zero;
   logic        out_valid;
   logic        out_ready;

   always #5 clk = ~clk;

   log2_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_ln_mode (in_ln_mode),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_zero   (out_zero),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   typedef struct {
      int   id;
      int   data;
      logic zero;
      int   tol;
      bit   lat;
      int   cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          next_id = 0;
   int          corr_tab[65];
   bit          prev_stall = 1'b0;
   logic [15:0] prev_data = 16'h0;
   logic        prev_zero = 1'b0;

   task automatic check_val(input string tag, input int obs, input int exp, input int tol = 0);
      int d;
      n_cmp++;
      d = obs - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d", tag, obs, obs, exp, exp, tol);
      end
   endtask

   // Reference: true log2 via leading one, 16-bit mantissa, interpolated correction.
   function automatic int model(input logic [31:0] x, input logic ln);
      int     p;
      longint rem;
      longint f;
      longint t;
      int     i;
      int     r;
      int     c;
      int     y;
      if (x == 32'd0) return -32768;
      p = 0;
      for (int b = 0; b < 32; b++) if (x[b]) p = b;
      rem = longint'(x) - (longint'(1) << p);
      if (p >= 16) f = rem >>> (p - 16);
      else         f = rem << (16 - p);
      i = int'(f >>> 10);
      r = int'(f % 1024);
      c = corr_tab[i] + ((((corr_tab[i+1] - corr_tab[i]) * r) + 512) >>> 10);
      y = (p - 16) * 1024 + int'(f >>> 6) + c;
      if (ln) begin
         t = longint'(y) * 64'sd45426 + 64'sd32768;
         y = int'(t >>> 16);
      end
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      return y;
   endfunction

   task automatic cycle(input logic v, input logic [31:0] d, input logic ln, input logic ordy,
                        input int exp_d, input logic exp_z, input int tol, input bit lat,
                        output bit xfer);
      exp_t e;
      in_valid   = v;
      in_data    = d;
      in_ln_mode = ln;
      out_ready  = ordy;
      #1;
      xfer = 1'b0;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_val("stall_valid", int'(out_valid), 1);
            check_val("stall_data", int'(out_data), int'(prev_data));
            check_val("stall_zero", int'(out_zero), int'(prev_zero));
         end
         check_val("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check_val("spurious_out", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check_val($sformatf("data#%0d", e.id), int'($signed(out_data)), e.data, e.tol);
               check_val($sformatf("zero#%0d", e.id), int'(out_zero), int'(e.zero));
               if (e.lat) check_val($sformatf("latency#%0d", e.id), cyc - e.cyc, 5);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_zero  = out_zero;
         if (v && in_ready) begin
            e.id   = next_id;
            e.data = exp_d;
            e.zero = exp_z;
            e.tol  = tol;
            e.lat  = lat;
            e.cyc  = cyc;
            next_id++;
            sb_q.push_back(e);
            xfer = 1'b1;
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic send_dir(input logic [31:0] d, input logic ln, input int exp_d, input logic exp_z, input int tol);
      bit x;
      cycle(1'b1, d, ln, 1'b1, exp_d, exp_z, tol, 1'b1, x);
      check_val("dir_accept", int'(x), 1);
   endtask

   task automatic idle(input logic ordy, input int n);
      bit x;
      repeat (n) cycle(1'b0, 32'h0, 1'b0, ordy, 0, 1'b0, 0, 1'b0, x);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb_q.size() > 0 && guard < 100) begin
         idle(1'b1, 1);
         guard++;
      end
      check_val("drain", sb_q.size(), 0);
   endtask

   initial begin
      bit          x;
      int          sent;
      int          guard;
      logic [31:0] d;
      logic        ln;
      logic        ordy;

      for (int j = 0; j < 65; j++)
         corr_tab[j] = int'($floor(($ln(1.0 + real'(j) / 64.0) / $ln(2.0) - real'(j) / 64.0) * 1024.0 + 0.5));

      rst = 1'b1;
      in_valid = 1'b0; in_data = 32'h0; in_ln_mode = 1'b0; out_ready = 1'b0;
      idle(1'b0, 2);
      check_val("rst_valid", int'(out_valid), 0);
      check_val("rst_data", int'(out_data), 0);
      check_val("rst_zero", int'(out_zero), 0);
      rst = 1'b0;
      out_ready = 1'b0;
      #1;
      check_val("rst_in_ready", int'(in_ready), 1);
      @(negedge clk);
      cyc++;

      // Directed values, streamed back-to-back with latency checked on each.
      send_dir(32'h0001_0000, 1'b0, 0, 1'b0, 0);
      send_dir(32'h0002_0000, 1'b0, 1024, 1'b0, 0);
      send_dir(32'h0000_8000, 1'b0, -1024, 1'b0, 0);
      send_dir(32'h0003_0000, 1'b0, 1623, 1'b0, 1);
      send_dir(32'hFFFF_FFFF, 1'b0, 16384, 1'b0, 1);
      send_dir(32'h0000_0001, 1'b0, -16384, 1'b0, 0);
      send_dir(32'h0000_0000, 1'b0, -32768, 1'b1, 0);
      send_dir(32'h0000_0000, 1'b1, -32768, 1'b1, 0);
      send_dir(32'h0002_0000, 1'b1, 710, 1'b0, 1);
      send_dir(32'h0002_0000, 1'b0, 1024, 1'b0, 0);
      drain();

      // Random stream against the model with pseudo-random downstream stalls.
      sent = 0;
      guard = 0;
      while (sent < 20 && guard < 500) begin
         d    = $urandom() >> $urandom_range(0, 31);
         ln   = 1'($urandom_range(0, 1));
         ordy = 1'($urandom_range(0, 1));
         cycle(1'b1, d, ln, ordy, model(d, ln), (d == 32'h0), 0, 1'b0, x);
         if (x) sent++;
         guard++;
      end
      check_val("bp_sent", sent, 20);
      drain();

      // Reset with three samples in flight: nothing may emerge afterwards.
      cycle(1'b1, 32'h0005_0000, 1'b0, 1'b1, model(32'h0005_0000, 1'b0), 1'b0, 0, 1'b1, x);
      cycle(1'b1, 32'h0000_1234, 1'b1, 1'b1, model(32'h0000_1234, 1'b1), 1'b0, 0, 1'b1, x);
      cycle(1'b1, 32'h00F0_0000, 1'b0, 1'b1, model(32'h00F0_0000, 1'b0), 1'b0, 0, 1'b1, x);
      rst = 1'b1;
      idle(1'b1, 1);
      rst = 1'b0;
      sb_q.delete();
      check_val("flush_valid", int'(out_valid), 0);
      for (int n = 0; n < 6; n++) begin
         idle(1'b1, 1);
         check_val("flush_valid", int'(out_valid), 0);
      end
      send_dir(32'h0002_0000, 1'b0, 1024, 1'b0, 0);
      drain();
      idle(1'b1, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
